// File: rtl/mcu_zigzag_serializer_if.sv
// Coefficient stream from the zigzag serializer to the entropy-coding stage.
// Transfer happens on a cycle where coef_valid && coef_ready.
interface mcu_zigzag_serializer_if #(
  parameter int unsigned COEF_W = 32
);
  logic [COEF_W-1:0] coef_out;
  logic              coef_valid;
  logic              coef_ready;
  logic              coef_last_in_mcu;
  logic              coef_last_frame;

  modport master (
    output coef_out,
    output coef_valid,
    input  coef_ready,
    output coef_last_in_mcu,
    output coef_last_frame
  );

  modport slave (
    input  coef_out,
    input  coef_valid,
    output coef_ready,
    input  coef_last_in_mcu,
    input  coef_last_frame
  );
endinterface

// File: rtl/mcu_zigzag_serializer.sv
// Walks mcu_sel over a frame of MCUs, captures each 8x8 block and streams it out one coef at a time.
// Define MCU_ZIGZAG_EN for JPEG zigzag order; otherwise coefs stream in raster order.
module mcu_zigzag_serializer #(
  parameter int unsigned NUM_MCU = 28,
  parameter int unsigned SEL_W   = 11,
  parameter int unsigned COEF_W  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic [SEL_W-1:0]              mcu_sel,
  input  logic [7:0][7:0][COEF_W-1:0]   mcu_in,
  mcu_zigzag_serializer_if.master       coef_if,
  output logic                          busy,
  output logic                          done
);

  localparam logic [SEL_W-1:0] LastSel = SEL_W'(NUM_MCU - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  state_e                       state_q, state_d;
  logic [SEL_W-1:0]             sel_q, sel_d;
  logic [5:0]                   k_q, k_d;
  logic [7:0][7:0][COEF_W-1:0]  cap_q, cap_d;

  logic       valid;
  logic       xfer;
  logic [5:0] pos;

`ifdef MCU_ZIGZAG_EN
  // Raster index (row*8 + col) of the k-th zigzag coefficient.
  localparam logic [5:0] ZzTable [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  assign pos = ZzTable[k_q];
`else
  assign pos = k_q;
`endif

  assign valid = (state_q == StStream);
  assign xfer  = valid && coef_if.coef_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      k_q     <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      k_q     <= k_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    k_d     = k_q;
    cap_d   = cap_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sel_d   = '0;
          k_d     = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // mcu_in already reflects the registered mcu_sel
        cap_d   = mcu_in;
        state_d = StStream;
      end
      StStream: begin
        if (xfer) begin
          if (k_q == 6'd63) begin
            if (sel_q == LastSel) begin
              state_d = StDone;
            end else begin
              sel_d   = sel_q + SEL_W'(1);
              k_d     = '0;
              state_d = StLoad;
            end
          end else begin
            k_d = k_q + 6'd1;
          end
        end
      end
      StDone: begin
        sel_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mcu_sel                  = sel_q;
  assign busy                     = (state_q == StLoad) || (state_q == StStream);
  assign done                     = (state_q == StDone);
  assign coef_if.coef_valid       = valid;
  assign coef_if.coef_out         = valid ? cap_q[pos[5:3]][pos[2:0]] : '0;
  assign coef_if.coef_last_in_mcu = valid && (k_q == 6'd63);
  assign coef_if.coef_last_frame  = valid && (k_q == 6'd63) && (sel_q == LastSel);

endmodule
